keypad_test_ctrl: RTL and testbench



---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_test_ctrl_lfsr8.sv | 28 ++
 rtl/keypad_test_ctrl.sv | 146 ++++++++++++++
 tb/tb_keypad_test_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad typing-test controller:
//   FSM state encoding, the start key code, score counter width and
//   ceiling, and the LFSR / saturating-counter helper functions.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] KEY_START = 4'hF;

   localparam int              CNT_W   = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

   // Fibonacci step for x^8+x^6+x^5+x^4+1 (taps on bits 7,5,4,3).
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Increment that sticks at CNT_MAX.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/keypad_test_ctrl_lfsr8.sv
// lfsr8
//   8-bit Fibonacci LFSR producing the pseudo-random target digit.
//   Only rst reloads the seed, so successive tests continue the sequence.
// Ports:
//   clk  in  1 : system clock
//   rst  in  1 : synchronous active-high reset, loads SEED
//   step in  1 : advance one step this cycle
//   q    out 8 : current LFSR value
module lfsr8
   import keypad_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [7:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= SEED;
      end else if (step) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/keypad_test_ctrl.sv
// keypad_test_ctrl
//   Sequences a timed typing test around a 4x4 keypad decoder. Each
//   rising edge of key_valid is one key event. In IDLE the start key
//   (4'hF) clears the scores and starts a countdown of TEST_MS ms; in RUN
//   each event is scored against the target digit; when the countdown
//   reaches zero the block sits in DONE until the start key returns it
//   to IDLE, where the last result stays visible.
// Ports:
//   clk         in  1  : system clock
//   rst         in  1  : synchronous active-high reset
//   key_valid   in  1  : decoder button_pressed level
//   key_code    in  4  : decoder dec_out
//   target      out 4  : digit to press (low nibble of the LFSR)
//   correct_cnt out 10 : hits, saturating
//   error_cnt   out 10 : misses, saturating
//   ms_left     out 16 : remaining test time in ms
//   state       out 2  : IDLE=0, RUN=1, DONE=2
//   hit         out 1  : one-cycle pulse on a correct key
//   miss        out 1  : one-cycle pulse on a wrong key
//   done        out 1  : high while in DONE
module keypad_test_ctrl
   import keypad_pkg::*;
#(
   parameter int         TICK_CYCLES = 100_000,
   parameter int         TEST_MS     = 30_000,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   output logic [3:0]       target,
   output logic [CNT_W-1:0] correct_cnt,
   output logic [CNT_W-1:0] error_cnt,
   output logic [15:0]      ms_left,
   output logic [1:0]       state,
   output logic             hit,
   output logic             miss,
   output logic             done
);

   localparam int             PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [15:0]    MS_INIT    = 16'(TEST_MS);

   state_t        state_r;
   logic          key_valid_q;
   logic          key_event;
   logic [PW-1:0] presc;
   logic          lfsr_step;
   logic [3:0]    lfsr_lo;
   logic [3:0]    lfsr_hi_unused;  // upper bits only feed the shift register

   // Key input protocol: key_valid is a level with no back-pressure. A key
   // event is the cycle key_valid rises; key_code is taken in that same
   // cycle. Holding the key or releasing it produces no further events, so
   // the decoder's release code is never scored.
   assign key_event = key_valid & ~key_valid_q;

   // Only a correct key during RUN moves the target on.
   assign lfsr_step = (state_r == ST_RUN) && key_event && (key_code == lfsr_lo);

   lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .step (lfsr_step),
      .q    ({lfsr_hi_unused, lfsr_lo})
   );

   assign target = lfsr_lo;
   assign state  = state_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         key_valid_q <= 1'b0;
         presc       <= '0;
         correct_cnt <= '0;
         error_cnt   <= '0;
         ms_left     <= MS_INIT;
         hit         <= 1'b0;
         miss        <= 1'b0;
         done        <= 1'b0;
      end else begin
         key_valid_q <= key_valid;
         hit         <= 1'b0;
         miss        <= 1'b0;

         case (state_r)
            ST_IDLE: begin
               // Start key is consumed here and never scored.
               if (key_event && key_code == KEY_START) begin
                  correct_cnt <= '0;
                  error_cnt   <= '0;
                  ms_left     <= MS_INIT;
                  presc       <= '0;
                  state_r     <= ST_RUN;
               end
            end

            ST_RUN: begin
               // Scoring and the countdown are independent, so a key landing
               // on the final tick is still scored as DONE is entered.
               if (key_event) begin
                  if (key_code == lfsr_lo) begin
                     hit         <= 1'b1;
                     correct_cnt <= sat_inc(correct_cnt);
                  end else begin
                     miss        <= 1'b1;
                     error_cnt   <= sat_inc(error_cnt);
                  end
               end

               if (presc == PRESC_LAST) begin
                  presc   <= '0;
                  ms_left <= ms_left - 16'd1;
                  if (ms_left == 16'd1) begin
                     state_r <= ST_DONE;
                     done    <= 1'b1;
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end

            ST_DONE: begin
               ms_left <= '0;
               // Start key only acknowledges the result; a new test needs
               // a second start press from IDLE.
               if (key_event && key_code == KEY_START) begin
                  state_r <= ST_IDLE;
                  done    <= 1'b0;
               end
            end

            default: begin
               state_r <= ST_IDLE;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_test_ctrl.sv
// tb_keypad_test_ctrl
//   Bench for keypad_test_ctrl. A small-timing instance (TICK 4, 10 ms)
//   is followed cycle by cycle by a behavioural model; a second instance
//   with a long test is used to drive the error counter into saturation.
module tb_keypad_test_ctrl;

   localparam int         TICK = 4;
   localparam int         TMS  = 10;
   localparam int         TMS2 = 1000;
   localparam logic [7:0] SEED = 8'hA5;
   localparam int         W    = 45;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst  = 1'b1;
   logic       kv   = 1'b0;
   logic [3:0] kc   = 4'h0;
   logic       rst2 = 1'b1;
   logic       kv2  = 1'b0;
   logic [3:0] kc2  = 4'h0;

   initial begin
      repeat (2) @(negedge clk);
      rst2 = 1'b0;
   end

   logic [3:0]  target, target2;
   logic [9:0]  correct_cnt, error_cnt, correct_cnt2, error_cnt2;
   logic [15:0] ms_left, ms_left2;
   logic [1:0]  state, state2;
   logic        hit, miss, done, hit2, miss2, done2;

   keypad_test_ctrl #(.TICK_CYCLES(TICK), .TEST_MS(TMS), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst(rst), .key_valid(kv), .key_code(kc),
      .target(target), .correct_cnt(correct_cnt), .error_cnt(error_cnt),
      .ms_left(ms_left), .state(state), .hit(hit), .miss(miss), .done(done)
   );

   keypad_test_ctrl #(.TICK_CYCLES(TICK), .TEST_MS(TMS2), .LFSR_SEED(SEED)) dut_sat (
      .clk(clk), .rst(rst2), .key_valid(kv2), .key_code(kc2),
      .target(target2), .correct_cnt(correct_cnt2), .error_cnt(error_cnt2),
      .ms_left(ms_left2), .state(state2), .hit(hit2), .miss(miss2), .done(done2)
   );

   // ---------------- bookkeeping ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model + scoreboard ----------------
   // Time is tracked as cycles elapsed since the test started; ms_left and
   // the end of the test follow from that count by division.
   int         m_state   = 0;
   int         m_correct = 0;
   int         m_error   = 0;
   int         m_ms      = TMS;
   int         m_elapsed = 0;
   logic [7:0] m_lfsr    = SEED;
   bit         m_prev    = 1'b0;
   bit         m_hit     = 1'b0;
   bit         m_miss    = 1'b0;
   bit         m_ev;
   logic [W-1:0] exp_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_state = 0; m_correct = 0; m_error = 0; m_ms = TMS; m_elapsed = 0;
         m_lfsr = SEED; m_prev = 1'b0; m_hit = 1'b0; m_miss = 1'b0;
      end else begin
         m_ev   = kv && !m_prev;
         m_prev = kv;
         m_hit  = 1'b0;
         m_miss = 1'b0;
         if (m_state == 1) begin
            if (m_ev) begin
               if (kc == m_lfsr[3:0]) begin
                  m_hit = 1'b1;
                  if (m_correct < 1023) m_correct++;
                  m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
               end else begin
                  m_miss = 1'b1;
                  if (m_error < 1023) m_error++;
               end
            end
            m_elapsed++;
            m_ms = TMS - m_elapsed / TICK;
            if (m_elapsed == TMS * TICK) m_state = 2;
         end else if (m_ev && kc == 4'hF) begin
            if (m_state == 0) begin
               m_state = 1; m_correct = 0; m_error = 0; m_elapsed = 0; m_ms = TMS;
            end else begin
               m_state = 0;
            end
         end
      end
      exp_q.push_back({2'(m_state), m_lfsr[3:0], 10'(m_correct), 10'(m_error),
                       16'(m_ms), m_hit, m_miss, (m_state == 2)});
   end

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("model", {state, target, correct_cnt, error_cnt, ms_left, hit, miss, done}, e);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic press(input logic [3:0] code);
      @(negedge clk); kv = 1'b1; kc = code;
      @(negedge clk); kv = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       r; logic v; logic [3:0] c;
      logic [1:0] st; logic [3:0] tg; logic [9:0] cc; logic [9:0] ec;
      logic [15:0] ms; logic h; logic m; logic d;
   } vec_t;

   vec_t tbl[8];

   int miss_seen;
   int cyc;
   int r;
   int p;

   initial begin
      // reset, start (not scored), first hit: A5 steps to 4A so target -> A
      tbl[0] = '{1'b1, 1'b0, 4'h0, 2'd0, 4'h5, 10'd0, 10'd0, 16'd10, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 4'h0, 2'd0, 4'h5, 10'd0, 10'd0, 16'd10, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 4'h0, 2'd0, 4'h5, 10'd0, 10'd0, 16'd10, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 4'hF, 2'd1, 4'h5, 10'd0, 10'd0, 16'd10, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 4'hF, 2'd1, 4'h5, 10'd0, 10'd0, 16'd10, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 4'h5, 2'd1, 4'hA, 10'd1, 10'd0, 16'd10, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 4'h5, 2'd1, 4'hA, 10'd1, 10'd0, 16'd10, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 4'h5, 2'd1, 4'hA, 10'd1, 10'd0, 16'd9,  1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rst = tbl[i].r; kv = tbl[i].v; kc = tbl[i].c;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i),
               {state, target, correct_cnt, error_cnt, ms_left, hit, miss, done},
               {tbl[i].st, tbl[i].tg, tbl[i].cc, tbl[i].ec, tbl[i].ms, tbl[i].h, tbl[i].m, tbl[i].d});
      end

      // held wrong key: one miss only, target unchanged
      @(negedge clk); kv = 1'b1; kc = 4'h0;
      miss_seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         miss_seen += int'(miss);
      end
      check("held_miss_pulses", miss_seen, 1);
      check("held_err_cnt", error_cnt, 10'd1);
      check("held_target", target, 4'hA);
      @(negedge clk); kv = 1'b0;

      // let this test expire, then acknowledge: counters retained
      cyc = 0;
      while (!done && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      check("first_timeout_done", done, 1'b1);
      press(4'hF);
      check("ack_state", state, 2'd0);
      check("ack_done", done, 1'b0);
      check("ack_counts", {correct_cnt, error_cnt}, {10'd1, 10'd1});
      check("ack_ms_left", ms_left, 16'd0);

      // timeout with no keys: DONE after TEST_MS*TICK cycles
      @(negedge clk); kv = 1'b1; kc = 4'hF;
      @(posedge clk); #1;
      check("start_state", state, 2'd1);
      check("start_ms", ms_left, 16'd10);
      check("start_clear", {correct_cnt, error_cnt}, 20'd0);
      @(negedge clk); kv = 1'b0;
      cyc = 0;
      while (!done && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      n_cmp++;
      if (cyc < 39 || cyc > 41) begin
         n_fail++;
         $display("FAIL timeout_cycles: got %0d expected 40+-1", cyc);
      end
      check("timeout_state", state, 2'd2);
      check("timeout_ms", ms_left, 16'd0);
      press(4'hF);
      check("done_ack_state", state, 2'd0);
      check("done_ack_done", done, 1'b0);

      // randomized traffic, including occasional reset
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         r = $urandom_range(0, 9);
         if (r < 4) kv = ~kv;
         p = $urandom_range(0, 9);
         if (p < 5)      kc = m_lfsr[3:0];
         else if (p < 7) kc = 4'hF;
         else            kc = 4'($urandom_range(0, 15));
      end
      @(negedge clk); rst = 1'b1; kv = 1'b0;
      @(negedge clk); rst = 1'b0;

      // correct key sampled on the same edge as the final tick
      @(negedge clk); kv = 1'b1; kc = 4'hF;
      @(negedge clk); kv = 1'b0;
      repeat (39) @(negedge clk);
      kv = 1'b1; kc = m_lfsr[3:0];
      @(posedge clk); #1;
      check("final_tick_hit", hit, 1'b1);
      check("final_tick_correct", correct_cnt, 10'd1);
      check("final_tick_state", state, 2'd2);
      check("final_tick_done", done, 1'b1);
      @(negedge clk); kv = 1'b0;

      // saturation on the long-test instance, then reset mid-test
      @(negedge clk); kv2 = 1'b1; kc2 = 4'hF;
      @(negedge clk); kv2 = 1'b0;
      for (int i = 0; i < 1023; i++) begin
         @(negedge clk); kv2 = 1'b1; kc2 = 4'h0;
         @(negedge clk); kv2 = 1'b0;
      end
      check("sat_err_1023", error_cnt2, 10'd1023);
      check("sat_state_run", state2, 2'd1);
      @(negedge clk); kv2 = 1'b1; kc2 = 4'h0;
      @(posedge clk); #1;
      check("sat_miss_pulse", miss2, 1'b1);
      check("sat_err_hold", error_cnt2, 10'd1023);
      @(negedge clk); kv2 = 1'b0; rst2 = 1'b1;
      @(posedge clk); #1;
      check("midrst_vals",
            {state2, target2, correct_cnt2, error_cnt2, ms_left2, hit2, miss2, done2},
            {2'd0, 4'h5, 10'd0, 10'd0, 16'd1000, 1'b0, 1'b0, 1'b0});
      @(negedge clk); rst2 = 1'b0;

      // ---------------- report ----------------
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
